// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/sequencing stage of the 4-bit core.
package fetch_pkg;

    localparam int ADDR_W = 12;
    localparam int OPC_W  = 4;

    localparam logic PHASE_FETCH = 1'b0;
    localparam logic PHASE_EXEC  = 1'b1;

    typedef enum logic {
        ST_FETCH = PHASE_FETCH,
        ST_EXEC  = PHASE_EXEC
    } phase_e;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic             c;
        logic             z;
        logic             phase;
    } dec_addr_t;

    function automatic dec_addr_t pack_decode(
        input logic [OPC_W-1:0] opcode,
        input logic             c,
        input logic             z,
        input logic             phase
    );
        dec_addr_t d;
        d.opcode = opcode;
        d.c      = c;
        d.z      = z;
        d.phase  = phase;
        return d;
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: asynchronous reset, enable, load-over-increment priority.
module fetch_pc #(
    parameter int              ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_target,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;

    // Next-PC selection; increment wraps naturally at the top of the address space.
    always_comb begin
        w_pc_nxt = r_pc;
        if (!i_en) begin
            w_pc_nxt = r_pc;
        end else if (i_load) begin
            w_pc_nxt = i_target;
        end else if (i_inc) begin
            w_pc_nxt = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            w_pc_nxt = r_pc;
        end
    end

    // PC state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch/sequencing stage: PC, phase bit, IR and C/Z flags.
// Optional stall input is enabled by defining FETCH_STALL_EN.
module fetch_ctrl #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic              flags_we,
    input  logic              alu_c,
    input  logic              alu_z,
    output logic [6:0]        decode_addr,
    output logic [3:0]        operand,
    output logic              phase
`ifdef FETCH_STALL_EN
    ,
    input  logic              hold
`endif
);

    import fetch_pkg::*;

    phase_e            r_phase;
    phase_e            w_phase_nxt;
    logic [7:0]        r_ir;
    logic [7:0]        w_ir_nxt;
    logic              r_c_flag;
    logic              r_z_flag;
    logic              w_c_nxt;
    logic              w_z_nxt;
    logic              w_en;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc;
    dec_addr_t         w_dec;

`ifdef FETCH_STALL_EN
    assign w_en = ~hold;
`else
    assign w_en = 1'b1;
`endif

    // In EXEC, rom_data is the second instruction byte (low 8 bits of the target).
    assign w_target = ADDR_W'({r_ir[3:0], rom_data});

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_en),
        .i_load   (pc_load),
        .i_inc    (pc_inc),
        .i_target (w_target),
        .o_pc     (w_pc)
    );

    // Phase machine next-state, IR capture and flag capture.
    always_comb begin
        w_phase_nxt = r_phase;
        w_ir_nxt    = r_ir;
        w_c_nxt     = r_c_flag;
        w_z_nxt     = r_z_flag;
        if (w_en) begin
            case (r_phase)
                ST_FETCH: begin
                    w_ir_nxt    = rom_data;
                    w_phase_nxt = ST_EXEC;
                end
                ST_EXEC: begin
                    w_phase_nxt = ST_FETCH;
                    if (flags_we) begin
                        w_c_nxt = alu_c;
                        w_z_nxt = alu_z;
                    end else begin
                        w_c_nxt = r_c_flag;
                        w_z_nxt = r_z_flag;
                    end
                end
                default: begin
                    w_phase_nxt = ST_FETCH;
                end
            endcase
        end else begin
            w_phase_nxt = r_phase;
        end
    end

    // Phase, IR and flag state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase  <= ST_FETCH;
            r_ir     <= 8'h00;
            r_c_flag <= 1'b0;
            r_z_flag <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_ir     <= w_ir_nxt;
            r_c_flag <= w_c_nxt;
            r_z_flag <= w_z_nxt;
        end
    end

    assign w_dec       = pack_decode(r_ir[7:4], r_c_flag, r_z_flag, r_phase);
    assign decode_addr = w_dec;
    assign operand     = r_ir[3:0];
    assign phase       = r_phase;
    assign rom_addr    = w_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with an asynchronous ROM model.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  rom_data;
    logic [11:0] rom_addr;
    logic        pc_inc;
    logic        pc_load;
    logic        flags_we;
    logic        alu_c;
    logic        alu_z;
    logic [6:0]  decode_addr;
    logic [3:0]  operand;
    logic        phase;
`ifdef FETCH_STALL_EN
    logic        hold;
`endif

    logic [7:0]  rom [0:4095];
    int          n_checks;
    int          n_errors;

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .rom_data    (rom_data),
        .rom_addr    (rom_addr),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .flags_we    (flags_we),
        .alu_c       (alu_c),
        .alu_z       (alu_z),
        .decode_addr (decode_addr),
        .operand     (operand),
        .phase       (phase)
`ifdef FETCH_STALL_EN
        ,
        .hold        (hold)
`endif
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic inc, input logic ld, input logic fwe,
                         input logic c, input logic z);
        pc_inc   = inc;
        pc_load  = ld;
        flags_we = fwe;
        alu_c    = c;
        alu_z    = z;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[12'h000] = 8'hC3;
        rom[12'h001] = 8'h45;
        rom[12'h002] = 8'hB6;
        rom[12'h345] = 8'h2A;
        rom[12'h346] = 8'h81;
        rom[12'h347] = 8'h23;
        rom[12'h123] = 8'h0F;
        rom[12'h3C3] = 8'h5F;
        rom[12'h3C4] = 8'hFF;
        rom[12'hFFF] = 8'h77;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_STALL_EN
        hold = 1'b0;
`endif
        #2;
        chk("reset_rom_addr", 16'(rom_addr), 16'h000);
        chk("reset_decode", 16'(decode_addr), 16'h00);
        chk("reset_operand", 16'(operand), 16'h0);
        chk("reset_phase", 16'(phase), 16'h0);
        @(negedge clk);
        reset = 1'b0;

        // FETCH C3 at 000 with pc_inc
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("fetch1_rom_addr", 16'(rom_addr), 16'h001);
        chk("fetch1_decode", 16'(decode_addr), 16'h61);
        chk("fetch1_operand", 16'(operand), 16'h3);
        chk("fetch1_phase", 16'(phase), 16'h1);

        // EXEC jump: load+inc together, flags written C=1 Z=0
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk("jump_rom_addr", 16'(rom_addr), 16'h345);
        chk("jump_phase", 16'(phase), 16'h0);
        chk("jump_decode", 16'(decode_addr), 16'h64);

        // FETCH 2A; flags_we during FETCH must be ignored
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        chk("fetch2_rom_addr", 16'(rom_addr), 16'h346);
        chk("fetch2_decode", 16'(decode_addr), 16'h15);
        chk("fetch2_operand", 16'(operand), 16'hA);

        // EXEC: flag write only, PC holds
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        chk("exec2_rom_addr", 16'(rom_addr), 16'h346);
        chk("exec2_decode", 16'(decode_addr), 16'h12);
        chk("exec2_operand", 16'(operand), 16'hA);

        // FETCH 81, then EXEC jump to 123
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("fetch3_decode", 16'(decode_addr), 16'h43);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("jump2_rom_addr", 16'(rom_addr), 16'h123);
        chk("jump2_decode", 16'(decode_addr), 16'h42);

        // FETCH 0F with no strobes: PC holds
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("fetch4_rom_addr", 16'(rom_addr), 16'h123);
        chk("fetch4_decode", 16'(decode_addr), 16'h03);
        chk("fetch4_operand", 16'(operand), 16'hF);

        // Mid-cycle asynchronous reset
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_rom_addr", 16'(rom_addr), 16'h000);
        chk("midrst_decode", 16'(decode_addr), 16'h00);
        chk("midrst_operand", 16'(operand), 16'h0);
        chk("midrst_phase", 16'(phase), 16'h0);
        step();
        chk("rst_edge_phase", 16'(phase), 16'h0);
        #2;
        reset = 1'b0;

        // Restart: FETCH C3 at 000, no inc
        step();
        chk("restart_rom_addr", 16'(rom_addr), 16'h000);
        chk("restart_decode", 16'(decode_addr), 16'h61);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("restart_jump", 16'(rom_addr), 16'h3C3);
        chk("restart_jump_decode", 16'(decode_addr), 16'h60);

        // FETCH 5F, EXEC jump to FFF
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("fetch5_decode", 16'(decode_addr), 16'h29);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("to_fff_rom_addr", 16'(rom_addr), 16'hFFF);
        chk("to_fff_decode", 16'(decode_addr), 16'h28);

        // Wrap FFF -> 000 on pc_inc
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("wrap_rom_addr", 16'(rom_addr), 16'h000);
        chk("wrap_decode", 16'(decode_addr), 16'h39);
        chk("wrap_operand", 16'(operand), 16'h7);
        step();
        chk("exec_inc_rom_addr", 16'(rom_addr), 16'h001);
        chk("exec_inc_decode", 16'(decode_addr), 16'h38);

`ifdef FETCH_STALL_EN
        // FETCH 45, then stall EXEC for 3 cycles with load pending
        step();
        chk("stall_fetch_decode", 16'(decode_addr), 16'h21);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_rom_addr", 16'(rom_addr), 16'h002);
            chk("stall_phase", 16'(phase), 16'h1);
            chk("stall_decode", 16'(decode_addr), 16'h21);
        end
        hold = 1'b0;
        step();
        chk("unstall_rom_addr", 16'(rom_addr), 16'h5B6);
        chk("unstall_decode", 16'(decode_addr), 16'h24);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
